// File: rtl/mem_chk_sram.sv
// Single-port synchronous SRAM with per-word written-valid tracking, supply gating
// and a protocol/integrity checker (sticky flags, error pulse, saturating counter).
module mem_chk_sram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 4096,
  parameter int RD_LAT    = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [ADDR_W-1:0]    add,
  input  logic [DATA_W-1:0]    din,
  input  logic                 supply_ok,
  input  logic                 err_clr,
  output logic [DATA_W-1:0]    dout,
  output logic                 dout_vld,
  output logic [4:0]           err_status,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  localparam int ERR_CONFLICT = 0;
  localparam int ERR_UNINIT   = 1;
  localparam int ERR_RANGE    = 2;
  localparam int ERR_SUPPLY   = 3;
  localparam int ERR_DISABLED = 4;

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [DATA_W-1:0]    dout_q;
  logic                 dout_vld_q;
  logic [4:0]           err_status_q, err_status_d;
  logic                 err_pulse_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 in_range;
  logic [ADDR_W-1:0]    add_idx;
  logic                 valid_bit;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 rd_zero;
  logic [DATA_W-1:0]    rd_data;
  logic [4:0]           err_new;
  logic                 any_err;

  // Slot presented to the output register: legal data, forced zero, or hold.
  logic                 s_vld;
  logic                 s_zero;
  logic [DATA_W-1:0]    s_data;

  assign in_range  = ({1'b0, add} < DEPTH_L);
  assign add_idx   = in_range ? add : '0;
  assign valid_bit = in_range & valid_q[add_idx];
  assign rd_data   = mem_q[add_idx];

  assign wr_ok   = ~cen & wr & ~rd & in_range & supply_ok;
  assign rd_ok   = ~cen & rd & ~wr & in_range & supply_ok & valid_bit;
  assign rd_zero = ~cen & rd & ~rd_ok;

  // One error class per edge, highest priority first.
  always_comb begin
    err_new = '0;
    if (cen) begin
      if (rd | wr) err_new[ERR_DISABLED] = 1'b1;
    end else if (rd & wr) begin
      err_new[ERR_CONFLICT] = 1'b1;
    end else if ((rd | wr) & ~in_range) begin
      err_new[ERR_RANGE] = 1'b1;
    end else if ((rd | wr) & ~supply_ok) begin
      err_new[ERR_SUPPLY] = 1'b1;
    end else if (rd & ~valid_bit) begin
      err_new[ERR_UNINIT] = 1'b1;
    end
  end

  assign any_err = |err_new;

  // Array contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[add_idx] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_ok) begin
      valid_q[add_idx] <= 1'b1;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              st_vld_q;
      logic              st_zero_q;
      logic [DATA_W-1:0] st_data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          st_vld_q  <= 1'b0;
          st_zero_q <= 1'b0;
          st_data_q <= '0;
        end else if (cen) begin
          st_vld_q  <= 1'b0;
          st_zero_q <= 1'b0;
          st_data_q <= '0;
        end else begin
          st_vld_q  <= rd_ok;
          st_zero_q <= rd_zero;
          st_data_q <= rd_ok ? rd_data : '0;
        end
      end

      assign s_vld  = st_vld_q;
      assign s_zero = st_zero_q;
      assign s_data = st_data_q;
    end else begin : g_lat1
      assign s_vld  = rd_ok;
      assign s_zero = rd_zero;
      assign s_data = rd_data;
    end
  endgenerate

  // Chip disable flushes the output as well as any in-flight slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else if (cen) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else if (s_vld) begin
      dout_q     <= s_data;
      dout_vld_q <= 1'b1;
    end else begin
      if (s_zero) dout_q <= '0;
      dout_vld_q <= 1'b0;
    end
  end

  // A clear on the same edge as a new error keeps the new error.
  always_comb begin
    err_status_d = err_status_q;
    err_cnt_d    = err_cnt_q;
    if (err_clr) begin
      err_status_d = err_new;
      err_cnt_d    = any_err ? ERR_CNT_W'(1) : '0;
    end else if (any_err) begin
      err_status_d = err_status_q | err_new;
      if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_status_q <= '0;
      err_pulse_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      err_status_q <= err_status_d;
      err_pulse_q  <= any_err;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign err_status = err_status_q;
  assign err_pulse  = err_pulse_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_mem_chk_sram.sv
// Directed bench for mem_chk_sram: one instance at RD_LAT=1/DEPTH=4096 and one at
// RD_LAT=2/DEPTH=3000, both fed from the same command stream.
module tb_mem_chk_sram;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic        rd;
  logic        wr;
  logic [11:0] add;
  logic [7:0]  din;
  logic        supply_ok;
  logic        err_clr;

  logic [7:0]  dout1, dout2;
  logic        vld1, vld2;
  logic [4:0]  st1, st2;
  logic        pulse1, pulse2;
  logic [7:0]  cnt1, cnt2;

  int n_checks;
  int n_pass;

  mem_chk_sram #(.DATA_W(8), .ADDR_W(12), .DEPTH(4096), .RD_LAT(1), .ERR_CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .rd(rd), .wr(wr), .add(add), .din(din),
    .supply_ok(supply_ok), .err_clr(err_clr), .dout(dout1), .dout_vld(vld1),
    .err_status(st1), .err_pulse(pulse1), .err_cnt(cnt1)
  );

  mem_chk_sram #(.DATA_W(8), .ADDR_W(12), .DEPTH(3000), .RD_LAT(2), .ERR_CNT_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .rd(rd), .wr(wr), .add(add), .din(din),
    .supply_ok(supply_ok), .err_clr(err_clr), .dout(dout2), .dout_vld(vld2),
    .err_status(st2), .err_pulse(pulse2), .err_cnt(cnt2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Apply one command, let one rising edge sample it, settle 1ns past the edge.
  task automatic drive(input logic c, input logic r, input logic w,
                       input logic [11:0] a, input logic [7:0] d);
    cen = c; rd = r; wr = w; add = a; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 12'h000, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cen = 1'b1; rd = 1'b0; wr = 1'b0; add = '0; din = '0;
    supply_ok = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // ---------------- RD_LAT=1, DEPTH=4096 ----------------
    do_reset();
    check("rst_dout", 32'(dout1), 32'h00);
    check("rst_vld", 32'(vld1), 32'h0);
    check("rst_status", 32'(st1), 32'h00);
    check("rst_pulse", 32'(pulse1), 32'h0);
    check("rst_cnt", 32'(cnt1), 32'h00);

    drive(1'b0, 1'b0, 1'b1, 12'h2AA, 8'hAA);
    drive(1'b0, 1'b0, 1'b1, 12'h6CA, 8'hEA);
    drive(1'b0, 1'b0, 1'b1, 12'hEA8, 8'hBB);
    drive(1'b0, 1'b1, 1'b0, 12'h2AA, 8'h00);
    check("rd_2aa", 32'(dout1), 32'hAA);
    check("rd_2aa_vld", 32'(vld1), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 12'h6CA, 8'h00);
    check("rd_6ca", 32'(dout1), 32'hEA);
    drive(1'b0, 1'b1, 1'b0, 12'hEA8, 8'h00);
    check("rd_ea8", 32'(dout1), 32'hBB);
    check("rd_ea8_vld", 32'(vld1), 32'h1);
    check("rd_cnt0", 32'(cnt1), 32'h00);
    idle();
    check("idle_hold", 32'(dout1), 32'hBB);
    check("idle_vld", 32'(vld1), 32'h0);

    // uninitialised read
    drive(1'b0, 1'b1, 1'b0, 12'hFAD, 8'h00);
    check("uninit_dout", 32'(dout1), 32'h00);
    check("uninit_vld", 32'(vld1), 32'h0);
    check("uninit_status", 32'(st1), 32'h02);
    check("uninit_pulse", 32'(pulse1), 32'h1);
    check("uninit_cnt", 32'(cnt1), 32'h01);
    idle();
    check("pulse_drop", 32'(pulse1), 32'h0);

    // clear, then write while disabled and read back
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    check("clr_status", 32'(st1), 32'h00);
    check("clr_cnt", 32'(cnt1), 32'h00);
    drive(1'b1, 1'b0, 1'b1, 12'hFAE, 8'hFE);
    check("dis_status", 32'(st1), 32'h10);
    check("dis_pulse", 32'(pulse1), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 12'hFAE, 8'h00);
    check("dis_rd_status", 32'(st1), 32'h12);
    check("dis_rd_dout", 32'(dout1), 32'h00);
    check("dis_rd_cnt", 32'(cnt1), 32'h02);

    // conflict
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 12'h6CA, 8'h33);
    check("conf_status", 32'(st1), 32'h01);
    check("conf_vld", 32'(vld1), 32'h0);
    check("conf_dout", 32'(dout1), 32'h00);
    drive(1'b0, 1'b1, 1'b0, 12'h6CA, 8'h00);
    check("conf_rd", 32'(dout1), 32'hEA);

    // supply low blocks the write
    supply_ok = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 12'h6CA, 8'h55);
    supply_ok = 1'b1;
    check("sup_status", 32'(st1), 32'h09);
    drive(1'b0, 1'b1, 1'b0, 12'h6CA, 8'h00);
    check("sup_rd", 32'(dout1), 32'hEA);
    check("sup_rd_vld", 32'(vld1), 32'h1);

    // read-after-write on consecutive edges
    drive(1'b0, 1'b0, 1'b1, 12'h100, 8'h5C);
    drive(1'b0, 1'b1, 1'b0, 12'h100, 8'h00);
    check("raw_dout", 32'(dout1), 32'h5C);

    // error and clear on the same edge: error wins
    err_clr = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 12'h000, 8'h00);
    err_clr = 1'b0;
    check("clr_err_status", 32'(st1), 32'h10);
    check("clr_err_cnt", 32'(cnt1), 32'h01);
    check("cen_flush", 32'(dout1), 32'h00);

    // saturation
    for (int i = 0; i < 260; i++) drive(1'b1, 1'b1, 1'b0, 12'h000, 8'h00);
    check("cnt_sat", 32'(cnt1), 32'hFF);

    // ---------------- RD_LAT=2, DEPTH=3000 ----------------
    do_reset();
    check("l2_rst_dout", 32'(dout2), 32'h00);
    check("l2_rst_cnt", 32'(cnt2), 32'h00);
    drive(1'b0, 1'b0, 1'b1, 12'h010, 8'h11);
    drive(1'b0, 1'b0, 1'b1, 12'h020, 8'h22);
    drive(1'b0, 1'b0, 1'b1, 12'hBB7, 8'h33);
    drive(1'b0, 1'b1, 1'b0, 12'h010, 8'h00);
    check("l2_lat_vld", 32'(vld2), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 12'h020, 8'h00);
    check("l2_b0", 32'(dout2), 32'h11);
    check("l2_b0_vld", 32'(vld2), 32'h1);
    drive(1'b0, 1'b1, 1'b0, 12'hBB7, 8'h00);
    check("l2_b1", 32'(dout2), 32'h22);
    idle();
    check("l2_b2", 32'(dout2), 32'h33);
    check("l2_b2_vld", 32'(vld2), 32'h1);
    idle();
    check("l2_hold", 32'(dout2), 32'h33);
    check("l2_hold_vld", 32'(vld2), 32'h0);
    check("l2_cnt0", 32'(cnt2), 32'h00);

    // out of range
    drive(1'b0, 1'b0, 1'b1, 12'hBB8, 8'h77);
    check("l2_range_status", 32'(st2), 32'h04);
    check("l2_range_cnt", 32'(cnt2), 32'h01);
    drive(1'b0, 1'b1, 1'b0, 12'hBB8, 8'h00);
    check("l2_range_rd_cnt", 32'(cnt2), 32'h02);
    idle();
    check("l2_range_dout", 32'(dout2), 32'h00);
    check("l2_range_vld", 32'(vld2), 32'h0);

    // chip disable flushes an in-flight read
    drive(1'b0, 1'b1, 1'b0, 12'h010, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 12'h000, 8'h00);
    idle();
    check("l2_flush_dout", 32'(dout2), 32'h00);
    check("l2_flush_vld", 32'(vld2), 32'h0);

    // reset mid-burst
    drive(1'b0, 1'b1, 1'b0, 12'h010, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 12'h020, 8'h00);
    check("l2_pre_rst", 32'(dout2), 32'h11);
    rst_n = 1'b0;
    #1;
    check("l2_mid_rst_dout", 32'(dout2), 32'h00);
    check("l2_mid_rst_vld", 32'(vld2), 32'h0);
    #1;
    rst_n = 1'b1;
    idle();
    check("l2_post_rst_dout", 32'(dout2), 32'h00);
    check("l2_post_rst_vld", 32'(vld2), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
